// File: rtl/action_ram_arbiter.sv
// action_ram_arbiter
// Shares one action RAM (Q-value table) between the learning agent (A) and the
// host/loader (B). At most one access is granted per cycle; the granted command
// is registered onto the RAM ports and read data returns two cycles after the
// grant, tagged to the requester that issued it. A requester may hold a bounded
// lock so a read-modify-write sequence is not interleaved with the other side.
//
// Handshake: a requester raises req with we/lock/addr/wdata stable and keeps
// them stable until gnt. A cycle with req & gnt high is an accepted access.
// gnt is combinational from the current requests and the registered lock and
// round-robin state. rvalid is a single-cycle pulse per accepted read; rdata is
// the RAM output and is only meaningful while rvalid is high.

module action_ram_arbiter #(
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 16,
    parameter int MAX_LOCK = 8
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              a_req,
    input  logic              a_we,
    input  logic              a_lock,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic              b_lock,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,

    output logic              ram_write_enable,
    output logic [ADDR_W-1:0] ram_write_address,
    output logic [ADDR_W-1:0] ram_read_address,
    output logic [DATA_W-1:0] ram_d_in,
    input  logic [DATA_W-1:0] ram_d_out
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(MAX_LOCK);

    // Lock ownership: nobody, agent A, or host B.
    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_A    = 2'd1,
        LOCK_B    = 2'd2
    } lock_t;

    lock_t             lock_state;
    logic [CNT_W-1:0]  lock_cnt;    // contested grants given to the current owner
    logic              last_b;      // 1: B was granted most recently (A wins next tie)

    logic              contested;
    logic              lock_hold;
    logic              accept;
    logic              sel_we;
    logic              sel_lock;
    logic              other_req;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    lock_t             grant_side;
    logic [CNT_W-1:0]  cnt_base;
    logic [CNT_W-1:0]  cnt_next;

    // Read return pipeline: stage 1 = address being registered, stage 2 = RAM output valid.
    logic              rd1_valid;
    logic              rd1_b;
    logic              rd2_valid;
    logic              rd2_b;

    assign contested = a_req & b_req;
    assign lock_hold = (lock_state != LOCK_NONE) && (lock_cnt < LOCK_LIMIT);

    // Pick the winner: single requester wins outright, ties go to a live lock owner, else round-robin.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (contested) begin
            if (lock_hold) begin
                a_gnt = (lock_state == LOCK_A);
                b_gnt = (lock_state == LOCK_B);
            end else if (last_b) begin
                a_gnt = 1'b1;
            end else begin
                b_gnt = 1'b1;
            end
        end else begin
            a_gnt = a_req;
            b_gnt = b_req;
        end
    end

    assign accept = a_gnt | b_gnt;

    // Route the granted requester's command toward the RAM registers and lock tracking.
    always_comb begin
        sel_we     = a_we;
        sel_lock   = a_lock;
        sel_addr   = a_addr;
        sel_wdata  = a_wdata;
        other_req  = b_req;
        grant_side = LOCK_A;
        if (b_gnt) begin
            sel_we     = b_we;
            sel_lock   = b_lock;
            sel_addr   = b_addr;
            sel_wdata  = b_wdata;
            other_req  = a_req;
            grant_side = LOCK_B;
        end
    end

    // A new owner starts counting from zero; only grants that kept the other side waiting count.
    assign cnt_base = (lock_state == grant_side) ? lock_cnt : '0;
    assign cnt_next = cnt_base + {{(CNT_W-1){1'b0}}, other_req};

    // Lock owner, lock counter and round-robin pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            lock_state <= LOCK_NONE;
            lock_cnt   <= '0;
            last_b     <= 1'b1;
        end else if (accept) begin
            last_b <= b_gnt;
            if (sel_lock && (cnt_next != LOCK_LIMIT)) begin
                lock_state <= grant_side;
                lock_cnt   <= cnt_next;
            end else begin
                // Released by the owner, or the owner used up its contested budget.
                lock_state <= LOCK_NONE;
                lock_cnt   <= '0;
            end
        end else if (((lock_state == LOCK_A) && !a_req) ||
                     ((lock_state == LOCK_B) && !b_req)) begin
            lock_state <= LOCK_NONE;
            lock_cnt   <= '0;
        end
    end

    // Register the accepted command onto the RAM ports; idle cycles only drop the write strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            ram_write_enable  <= 1'b0;
            ram_write_address <= '0;
            ram_read_address  <= '0;
            ram_d_in          <= '0;
        end else begin
            ram_write_enable <= accept & sel_we;
            if (accept) begin
                ram_write_address <= sel_addr;
                ram_read_address  <= sel_addr;
                ram_d_in          <= sel_wdata;
            end
        end
    end

    // Track accepted reads so their data is flagged to the issuing side two cycles later.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd1_valid <= 1'b0;
            rd1_b     <= 1'b0;
            rd2_valid <= 1'b0;
            rd2_b     <= 1'b0;
        end else begin
            rd1_valid <= accept & ~sel_we;
            rd1_b     <= b_gnt;
            rd2_valid <= rd1_valid;
            rd2_b     <= rd1_b;
        end
    end

    assign a_rvalid = rd2_valid & ~rd2_b;
    assign b_rvalid = rd2_valid & rd2_b;
    assign a_rdata  = ram_d_out;
    assign b_rdata  = ram_d_out;

endmodule

// File: tb/tb_action_ram_arbiter.sv
// tb_action_ram_arbiter
// Drives action_ram_arbiter with directed tables, hand-written corner sequences
// and random traffic, and compares every cycle against a behavioural model of
// the arbitration rules, the RAM register contents and the read return stream.

module tb_action_ram_arbiter;

    localparam int ADDR_W   = 18;
    localparam int DATA_W   = 16;
    localparam int MAX_LOCK = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic              a_req, a_we, a_lock;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt, a_rvalid;
    logic [DATA_W-1:0] a_rdata;
    logic              b_req, b_we, b_lock;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt, b_rvalid;
    logic [DATA_W-1:0] b_rdata;
    logic              ram_write_enable;
    logic [ADDR_W-1:0] ram_write_address;
    logic [ADDR_W-1:0] ram_read_address;
    logic [DATA_W-1:0] ram_d_in;
    logic [DATA_W-1:0] ram_d_out;

    action_ram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK)
    ) dut (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_write_enable(ram_write_enable), .ram_write_address(ram_write_address),
        .ram_read_address(ram_read_address), .ram_d_in(ram_d_in), .ram_d_out(ram_d_out)
    );

    // ---------------- clock / reset / RAM ----------------
    always #5 clock = ~clock;

    logic [DATA_W-1:0] mem [0:255];

    // Synchronous RAM: write and read both take effect on the rising edge.
    always @(posedge clock) begin
        if (ram_write_enable) mem[ram_write_address[7:0]] <= ram_d_in;
        ram_d_out <= mem[ram_read_address[7:0]];
    end

    function automatic logic [DATA_W-1:0] init_val(input int i);
        return DATA_W'(i * 37 + 5);
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int                cyc_due;
        logic              side_b;
        logic [DATA_W-1:0] data;
    } rd_exp_t;

    rd_exp_t           exp_q[$];
    logic [DATA_W-1:0] m_mem [0:255];
    int                cyc;
    int                m_owner;     // 0 none, 1 A, 2 B
    int                m_run;       // contested grants the owner has had
    logic              m_last_b;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_din;

    int n_vec;
    int n_err;

    logic              obs_a_rvalid, obs_b_rvalid;
    logic [DATA_W-1:0] obs_a_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_owner  = 0;
        m_run    = 0;
        m_last_b = 1'b1;
        m_we     = 1'b0;
        m_addr   = '0;
        m_din    = '0;
    endtask

    // Compare the read return stream and RAM registers for the current cycle.
    task automatic check_outputs();
        logic              ea, eb;
        logic [DATA_W-1:0] ed;
        rd_exp_t           e;
        ea = 1'b0;
        eb = 1'b0;
        ed = '0;
        if (exp_q.size() > 0 && exp_q[0].cyc_due == cyc) begin
            e  = exp_q.pop_front();
            ea = ~e.side_b;
            eb = e.side_b;
            ed = e.data;
        end
        chk("a_rvalid", 32'(a_rvalid), 32'(ea));
        chk("b_rvalid", 32'(b_rvalid), 32'(eb));
        if (ea) chk("a_rdata", 32'(a_rdata), 32'(ed));
        if (eb) chk("b_rdata", 32'(b_rdata), 32'(ed));
        chk("ram_write_enable", 32'(ram_write_enable), 32'(m_we));
        chk("ram_write_address", 32'(ram_write_address), 32'(m_addr));
        chk("ram_read_address", 32'(ram_read_address), 32'(m_addr));
        chk("ram_d_in", 32'(ram_d_in), 32'(m_din));
        obs_a_rvalid = a_rvalid;
        obs_b_rvalid = b_rvalid;
        obs_a_rdata  = a_rdata;
    endtask

    // ---------------- driver tasks ----------------
    // One bus cycle: apply both requesters, check everything at the falling edge,
    // advance the model as of the rising edge that ends the cycle.
    task automatic step(
        input logic ar, input logic aw, input logic al,
        input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
        input logic br, input logic bw, input logic bl,
        input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd,
        output logic ga, output logic gb);
        int                winner;
        logic              we, lk, oreq;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wd;
        rd_exp_t           e;
        a_req = ar; a_we = aw; a_lock = al; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_lock = bl; b_addr = ba; b_wdata = bd;
        @(negedge clock);

        // Tie goes to a lock owner that still has budget, otherwise to whoever waited.
        if (ar && br) begin
            if (m_owner != 0 && m_run < MAX_LOCK) winner = m_owner;
            else                                  winner = m_last_b ? 1 : 2;
        end else begin
            winner = ar ? 1 : (br ? 2 : 0);
        end
        ga = (winner == 1);
        gb = (winner == 2);
        chk("a_gnt", 32'(a_gnt), 32'(ga));
        chk("b_gnt", 32'(b_gnt), 32'(gb));
        check_outputs();

        if (winner != 0) begin
            we   = gb ? bw : aw;
            lk   = gb ? bl : al;
            addr = gb ? ba : aa;
            wd   = gb ? bd : ad;
            oreq = gb ? ar : br;
            if (we) begin
                m_mem[addr[7:0]] = wd;
            end else begin
                e.cyc_due = cyc + 2;
                e.side_b  = gb;
                e.data    = m_mem[addr[7:0]];
                exp_q.push_back(e);
            end
            m_we     = we;
            m_addr   = addr;
            m_din    = wd;
            m_last_b = gb;
            if (lk) begin
                if (m_owner != winner) begin
                    m_owner = winner;
                    m_run   = 0;
                end
                if (oreq) m_run++;
                if (m_run == MAX_LOCK) begin
                    m_owner = 0;
                    m_run   = 0;
                end
            end else begin
                m_owner = 0;
                m_run   = 0;
            end
        end else begin
            m_we = 1'b0;
            if (m_owner != 0) begin
                m_owner = 0;
                m_run   = 0;
            end
        end
        cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        logic ga, gb;
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, 0, 0, 0, '0, '0, ga, gb);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        a_req = 1'b0;
        b_req = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            chk("rst_a_gnt", 32'(a_gnt), 32'd0);
            chk("rst_b_gnt", 32'(b_gnt), 32'd0);
            check_outputs();
            model_reset();
            cyc++;
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic ar, al, br;
        logic exp_a, exp_b;
    } vec_t;

    vec_t tbl[$];

    task automatic add_row(input logic ar, input logic al, input logic br,
                           input logic ea, input logic eb);
        vec_t v;
        v.ar = ar; v.al = al; v.br = br; v.exp_a = ea; v.exp_b = eb;
        tbl.push_back(v);
    endtask

    // ---------------- random traffic state ----------------
    logic              pa, pb;
    logic              rwa, rwb, rla, rlb;
    logic [ADDR_W-1:0] raa, rab;
    logic [DATA_W-1:0] rda, rdb;

    initial begin
        logic ga, gb;
        int   ai, bi, guard, a_seen, b_seen;

        for (int i = 0; i < 256; i++) begin
            mem[i]   = init_val(i);
            m_mem[i] = init_val(i);
        end
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        reset = 1'b1;
        a_req = 0; a_we = 0; a_lock = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_lock = 0; b_addr = '0; b_wdata = '0;
        model_reset();
        @(posedge clock);
        #1;
        do_reset(2);

        // Arbitration table: lock budget, round-robin, single requesters, budget counting.
        for (int i = 0; i < MAX_LOCK; i++) add_row(1, 1, 1, 1, 0);
        add_row(1, 1, 1, 0, 1);
        add_row(1, 0, 1, 1, 0);
        add_row(1, 0, 1, 0, 1);
        add_row(1, 0, 1, 1, 0);
        add_row(1, 0, 1, 0, 1);
        add_row(1, 0, 0, 1, 0);
        add_row(0, 0, 1, 0, 1);
        add_row(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add_row(1, 1, 0, 1, 0);
        for (int i = 0; i < MAX_LOCK; i++) add_row(1, 1, 1, 1, 0);
        add_row(1, 1, 1, 0, 1);
        add_row(0, 0, 0, 0, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].ar, 0, tbl[i].al, ADDR_W'(i), '0,
                 tbl[i].br, 0, 0, ADDR_W'(100 + i), '0, ga, gb);
            chk($sformatf("tbl%0d_a_gnt", i), 32'(ga), 32'(tbl[i].exp_a));
            chk($sformatf("tbl%0d_b_gnt", i), 32'(gb), 32'(tbl[i].exp_b));
        end
        idle(3);

        // Lone read right after reset: granted at once, data two cycles later.
        do_reset(1);
        step(1, 0, 0, 18'd5, '0, 0, 0, 0, '0, '0, ga, gb);
        chk("t1_gnt", 32'(ga), 32'd1);
        idle(1);
        chk("t1_no_early_rvalid", 32'(obs_a_rvalid), 32'd0);
        idle(1);
        chk("t1_rvalid", 32'(obs_a_rvalid), 32'd1);
        chk("t1_rdata", 32'(obs_a_rdata), 32'(init_val(5)));

        // Write then read the same address on the next cycle.
        step(1, 1, 0, 18'd5, 16'd12, 0, 0, 0, '0, '0, ga, gb);
        step(1, 0, 0, 18'd5, '0, 0, 0, 0, '0, '0, ga, gb);
        idle(1);
        chk("t3_no_write_rvalid", 32'(obs_a_rvalid), 32'd0);
        idle(1);
        chk("t3_rvalid", 32'(obs_a_rvalid), 32'd1);
        chk("t3_rdata", 32'(obs_a_rdata), 32'd12);

        // Interleaved reads from both sides: each data word goes back to its issuer.
        ai = 0; bi = 0; guard = 0; a_seen = 0; b_seen = 0;
        while ((ai < 4 || bi < 4) && guard < 40) begin
            step(ai < 4, 0, 0, ADDR_W'(10 + ai), '0, bi < 4, 0, 0, ADDR_W'(bi), '0, ga, gb);
            a_seen += int'(obs_a_rvalid);
            b_seen += int'(obs_b_rvalid);
            if (ga) ai++;
            if (gb) bi++;
            guard++;
        end
        chk("t6_issue_done", 32'(guard < 40), 32'd1);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            a_seen += int'(obs_a_rvalid);
            b_seen += int'(obs_b_rvalid);
        end
        chk("t6_a_rvalids", 32'(a_seen), 32'd4);
        chk("t6_b_rvalids", 32'(b_seen), 32'd4);

        // Reset right after a read: the read must never return.
        step(1, 0, 0, 18'd7, '0, 0, 0, 0, '0, '0, ga, gb);
        do_reset(1);
        idle(1);
        chk("t5_no_rvalid", 32'(obs_a_rvalid), 32'd0);
        idle(2);

        // Reset right after a write: strobe visible once, then low.
        step(0, 0, 0, '0, '0, 1, 1, 0, 18'd9, 16'hbeef, ga, gb);
        do_reset(1);
        idle(1);
        chk("t5_we_low", 32'(ram_write_enable), 32'd0);

        // Random traffic; requesters hold their command until granted.
        pa = 0; pb = 0;
        rwa = 0; rwb = 0; rla = 0; rlb = 0; raa = '0; rab = '0; rda = '0; rdb = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!pa && $urandom_range(0, 99) < 85) begin
                pa  = 1;
                rwa = ($urandom_range(0, 2) == 0);
                rla = ($urandom_range(0, 1) == 0);
                raa = ADDR_W'($urandom_range(0, 31));
                rda = DATA_W'($urandom);
            end
            if (!pb && $urandom_range(0, 99) < 60) begin
                pb  = 1;
                rwb = ($urandom_range(0, 3) == 0);
                rlb = ($urandom_range(0, 4) == 0);
                rab = ADDR_W'($urandom_range(0, 31));
                rdb = DATA_W'($urandom);
            end
            step(pa, rwa, rla, raa, rda, pb, rwb, rlb, rab, rdb, ga, gb);
            if (ga) pa = 0;
            if (gb) pb = 0;
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
